// File: rtl/control_pkg.sv
// Shared types for the Mini SRC control sequencer: sequencer states, opcodes,
// instruction classes and the control-strobe bundle.
package control_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch0,
    StFetch1,
    StFetch2,
    StT3,
    StT4,
    StT5,
    StT6,
    StT7,
    StHalt
  } state_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    ClsAlu,
    ClsImm,
    ClsMulDiv,
    ClsUnary,
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsBr,
    ClsJr,
    ClsJal,
    ClsIn,
    ClsOut,
    ClsMfhi,
    ClsMflo,
    ClsNop,
    ClsHalt
  } op_class_e;

  // Bit positions of the ALU-op one-hot.
  localparam int unsigned AluIncPc = 0;
  localparam int unsigned AluAdd   = 1;
  localparam int unsigned AluSub   = 2;
  localparam int unsigned AluMul   = 3;
  localparam int unsigned AluDiv   = 4;
  localparam int unsigned AluShr   = 5;
  localparam int unsigned AluShra  = 6;
  localparam int unsigned AluShl   = 7;
  localparam int unsigned AluRor   = 8;
  localparam int unsigned AluRol   = 9;
  localparam int unsigned AluAnd   = 10;
  localparam int unsigned AluOr    = 11;
  localparam int unsigned AluNeg   = 12;
  localparam int unsigned AluNot   = 13;
  localparam int unsigned AluWidth = 14;

  typedef logic [AluWidth-1:0] alu_op_t;

  typedef struct packed {
    logic    pc_out;
    logic    zlow_out;
    logic    zhigh_out;
    logic    mdr_out;
    logic    lo_out;
    logic    hi_out;
    logic    c_out;
    logic    ba_out;
    logic    r_out;
    logic    rin_out;
    logic    outport_out;
    logic    pc_in;
    logic    ir_in;
    logic    mar_in;
    logic    mdr_in;
    logic    y_in;
    logic    z_in;
    logic    lo_in;
    logic    hi_in;
    logic    r_in;
    logic    ra_in;
    logic    con_in;
    logic    outport_in;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    read;
    logic    write;
    alu_op_t alu;
  } ctrl_t;

endpackage

// File: rtl/op_class_decode.sv
// Opcode to instruction class plus the ALU-op one-hot that class applies.
// Undefined opcodes decode as nop.
module op_class_decode
  import control_pkg::*;
(
  input  logic [4:0] opcode_i,
  output op_class_e  op_class_o,
  output alu_op_t    alu_op_o
);

  always_comb begin
    op_class_o = ClsNop;
    alu_op_o   = '0;
    case (opcode_i)
      OpLd:   begin op_class_o = ClsLd;     alu_op_o[AluAdd]  = 1'b1; end
      OpLdi:  begin op_class_o = ClsLdi;    alu_op_o[AluAdd]  = 1'b1; end
      OpSt:   begin op_class_o = ClsSt;     alu_op_o[AluAdd]  = 1'b1; end
      OpAdd:  begin op_class_o = ClsAlu;    alu_op_o[AluAdd]  = 1'b1; end
      OpSub:  begin op_class_o = ClsAlu;    alu_op_o[AluSub]  = 1'b1; end
      OpAnd:  begin op_class_o = ClsAlu;    alu_op_o[AluAnd]  = 1'b1; end
      OpOr:   begin op_class_o = ClsAlu;    alu_op_o[AluOr]   = 1'b1; end
      OpRor:  begin op_class_o = ClsAlu;    alu_op_o[AluRor]  = 1'b1; end
      OpRol:  begin op_class_o = ClsAlu;    alu_op_o[AluRol]  = 1'b1; end
      OpShr:  begin op_class_o = ClsAlu;    alu_op_o[AluShr]  = 1'b1; end
      OpShra: begin op_class_o = ClsAlu;    alu_op_o[AluShra] = 1'b1; end
      OpShl:  begin op_class_o = ClsAlu;    alu_op_o[AluShl]  = 1'b1; end
      OpAddi: begin op_class_o = ClsImm;    alu_op_o[AluAdd]  = 1'b1; end
      OpAndi: begin op_class_o = ClsImm;    alu_op_o[AluAnd]  = 1'b1; end
      OpOri:  begin op_class_o = ClsImm;    alu_op_o[AluOr]   = 1'b1; end
      OpDiv:  begin op_class_o = ClsMulDiv; alu_op_o[AluDiv]  = 1'b1; end
      OpMul:  begin op_class_o = ClsMulDiv; alu_op_o[AluMul]  = 1'b1; end
      OpNeg:  begin op_class_o = ClsUnary;  alu_op_o[AluNeg]  = 1'b1; end
      OpNot:  begin op_class_o = ClsUnary;  alu_op_o[AluNot]  = 1'b1; end
      OpBr:   begin op_class_o = ClsBr;     alu_op_o[AluAdd]  = 1'b1; end
      OpJr:   op_class_o = ClsJr;
      OpJal:  op_class_o = ClsJal;
      OpIn:   op_class_o = ClsIn;
      OpOut:  op_class_o = ClsOut;
      OpMfhi: op_class_o = ClsMfhi;
      OpMflo: op_class_o = ClsMflo;
      OpHalt: op_class_o = ClsHalt;
      default: op_class_o = ClsNop;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: Moore FSM stepping fetch and per-class
// execute steps, driving each datapath strobe for exactly one cycle per step.
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        BranchOut,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        LOout,
  output logic        HIout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        RINout,
  output logic        OutPortOut,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic        Rin,
  output logic        RAin,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        AND,
  output logic        OR,
  output logic        NEG,
  output logic        NOT
);

  state_e    state_q, state_d;
  op_class_e op_class;
  alu_op_t   alu_op;
  ctrl_t     ctrl;

  // Only the opcode field matters to the sequencer.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  op_class_decode u_decode (
    .opcode_i   (IR[31:27]),
    .op_class_o (op_class),
    .alu_op_o   (alu_op)
  );

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    Run     = (state_q != StReset) && (state_q != StHalt);

    unique case (state_q)
      StReset: state_d = StFetch0;
      StFetch0: begin
        ctrl.pc_out          = 1'b1;
        ctrl.mar_in          = 1'b1;
        ctrl.alu[AluIncPc]   = 1'b1;
        ctrl.z_in            = 1'b1;
        state_d = Stop ? StHalt : StFetch1;
      end
      StFetch1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        state_d = StFetch2;
      end
      StFetch2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        if (op_class == ClsNop) begin
          state_d = StFetch0;
        end else if (op_class == ClsHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StT3;
        end
      end
      StT3: begin
        unique case (op_class)
          ClsAlu, ClsImm:      begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          ClsMulDiv:           begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          ClsUnary: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu = alu_op; ctrl.z_in = 1'b1;
          end
          ClsLd, ClsLdi, ClsSt: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
          ClsBr:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
          ClsJr:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          ClsJal:  begin ctrl.pc_out = 1'b1; ctrl.ra_in = 1'b1; end
          ClsIn:   begin ctrl.rin_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          ClsOut:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
          ClsMfhi: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          ClsMflo: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;
        endcase
        state_d = (op_class inside {ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo}) ? StFetch0 : StT4;
      end
      StT4: begin
        unique case (op_class)
          ClsAlu: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.alu = alu_op; ctrl.z_in = 1'b1;
          end
          ClsImm: begin ctrl.c_out = 1'b1; ctrl.alu = alu_op; ctrl.z_in = 1'b1; end
          ClsMulDiv: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu = alu_op; ctrl.z_in = 1'b1;
          end
          ClsUnary: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          ClsLd, ClsLdi, ClsSt: begin
            ctrl.c_out = 1'b1; ctrl.alu[AluAdd] = 1'b1; ctrl.z_in = 1'b1;
          end
          ClsBr:  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
          ClsJal: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          default: ;
        endcase
        state_d = (op_class inside {ClsUnary, ClsJal}) ? StFetch0 : StT5;
      end
      StT5: begin
        unique case (op_class)
          ClsAlu, ClsImm, ClsLdi: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          ClsMulDiv:    begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
          ClsLd, ClsSt: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
          ClsBr: begin ctrl.c_out = 1'b1; ctrl.alu[AluAdd] = 1'b1; ctrl.z_in = 1'b1; end
          default: ;
        endcase
        state_d = (op_class inside {ClsAlu, ClsImm, ClsLdi}) ? StFetch0 : StT6;
      end
      StT6: begin
        unique case (op_class)
          ClsMulDiv: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
          ClsLd:     begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
          ClsSt:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.write = 1'b1; end
          // Branch target was computed in T5; commit it only when CON FF is set.
          ClsBr: begin ctrl.zlow_out = BranchOut; ctrl.pc_in = BranchOut; end
          default: ;
        endcase
        state_d = (op_class == ClsLd) ? StT7 : StFetch0;
      end
      StT7: begin
        ctrl.mdr_out = 1'b1;
        ctrl.gra     = 1'b1;
        ctrl.r_in    = 1'b1;
        state_d = StFetch0;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  assign PCout      = ctrl.pc_out;
  assign Zlowout    = ctrl.zlow_out;
  assign Zhighout   = ctrl.zhigh_out;
  assign MDRout     = ctrl.mdr_out;
  assign LOout      = ctrl.lo_out;
  assign HIout      = ctrl.hi_out;
  assign Cout       = ctrl.c_out;
  assign BAout      = ctrl.ba_out;
  assign Rout       = ctrl.r_out;
  assign RINout     = ctrl.rin_out;
  assign OutPortOut = ctrl.outport_out;
  assign PCin       = ctrl.pc_in;
  assign IRin       = ctrl.ir_in;
  assign MARin      = ctrl.mar_in;
  assign MDRin      = ctrl.mdr_in;
  assign Yin        = ctrl.y_in;
  assign Zin        = ctrl.z_in;
  assign LOin       = ctrl.lo_in;
  assign HIin       = ctrl.hi_in;
  assign Rin        = ctrl.r_in;
  assign RAin       = ctrl.ra_in;
  assign CONin      = ctrl.con_in;
  assign OutPortIn  = ctrl.outport_in;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Read       = ctrl.read;
  assign Write      = ctrl.write;
  assign IncPC      = ctrl.alu[AluIncPc];
  assign ADD        = ctrl.alu[AluAdd];
  assign SUB        = ctrl.alu[AluSub];
  assign MUL        = ctrl.alu[AluMul];
  assign DIV        = ctrl.alu[AluDiv];
  assign SHR        = ctrl.alu[AluShr];
  assign SHRA       = ctrl.alu[AluShra];
  assign SHL        = ctrl.alu[AluShl];
  assign ROR        = ctrl.alu[AluRor];
  assign ROL        = ctrl.alu[AluRol];
  assign AND        = ctrl.alu[AluAnd];
  assign OR         = ctrl.alu[AluOr];
  assign NEG        = ctrl.alu[AluNeg];
  assign NOT        = ctrl.alu[AluNot];

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Mini SRC processor: the issuing end of the datapath's control interface. It reads the instruction register opcode and the CON FF branch result, steps a Moore state machine through fetch and per-class execute steps (T0..T7), and drives every datapath control strobe for exactly one clock per step. It sits beside the datapath at processor top level, between the Stop/Run pins and the datapath.

## Interface
Parameters: none (opcodes and states are fixed in the shared package).

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  synchronous, active-low reset.
- IR  in  32  instruction register contents; opcode IR[31:27].
- BranchOut  in  1  CON FF result.
- Stop  in  1  halt request.
- Run  out  1  high while executing.
- Bus-drive group, `out`, 1 each: PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout, RINout, OutPortOut.
- Register-load group, `out`, 1 each: PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin, RAin, CONin, OutPortIn.
- Register-select group, `out`, 1 each: Gra, Grb, Grc.
- Memory group, `out`, 1 each: Read, Write.
- ALU-op group, `out`, 1 each: IncPC, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT.

## Operation
- Moore outputs decode from the state register only, except T3 onward, which also uses the opcode class.
- Fetch:
  - FETCH0: PCout MARin IncPC Zin.
  - FETCH1: Zlowout PCin Read MDRin.
  - FETCH2: MDRout IRin.
- Execute steps by class; each sequence ends by returning to FETCH0.
  - R-type (add/sub/and/or/ror/rol/shr/shra/shl): T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout op Zin (ADD/AND/OR); T5 Zlowout Gra Rin.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout op Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not: T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
  - ld: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi: T3–T4 as ld; T5 Zlowout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout Write.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only if BranchOut=1, otherwise no strobes.
  - jr: T3 Gra Rout PCin. jal: T3 PCout RAin; T4 Gra Rout PCin.
  - in: T3 RINout Gra Rin. out: T3 Gra Rout OutPortIn.
  - mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
  - nop, and any undefined opcode: FETCH2 goes directly to FETCH0.
  - halt: enter HALT.
- States: RESET, FETCH0–2, T3–T7, HALT.
- HALT: all strobes 0, Run=0. Exit only through Clear.
- Stop=1 sampled in FETCH0 sends the next state to HALT; that FETCH0's strobes are still issued.
- At most one ALU-op strobe is active in any cycle.

## Timing
- Every strobe is asserted for the full cycle of its state; the datapath captures on the closing rising edge.
- Per-instruction latency is 3 fetch cycles plus the execute steps: R-type 6, ld 8, jr 4, nop 3.
- Clear=0 at any edge, including mid-instruction: next state RESET, all outputs 0, Run=0.
- The first edge with Clear=1 moves RESET to FETCH0; Run=1 from that FETCH0 cycle.
- BranchOut is sampled in T6, two edges after CONin. The datapath settles it by then.
- IR is stable from T3 until the next FETCH2 edge; the opcode is read directly, not latched.

## Structure
- control_pkg holds:
  - state enum (RESET, FETCH0–2, T3–T7, HALT);
  - 5-bit opcode constants ld=00000 … halt=11011 (add=00011, mul=10000, br=10011, jr=10100, jal=10101, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010);
  - opcode-class enum.
- One sub-module, op_class_decode: combinational, IR[31:27] to class plus the selected ALU-op one-hot.

## Test plan
- Reset:
  - Hold Clear=0 for 2 cycles: all outputs 0, Run=0.
  - Release: next cycle is FETCH0 with PCout MARin IncPC Zin asserted and Run=1.
- add R1,R2,R3 (IR=0x18918000):
  - 6-cycle sequence; T4 drives Grc Rout ADD Zin; T5 drives Zlowout Gra Rin.
  - FETCH0 follows; no two ALU-op strobes active together.
- ld R1,0x55(R0) (IR=0x00800055):
  - T3 BAout; T6 Read MDRin; T7 MDRout Gra Rin.
  - Total 8 cycles.
- brzr R2,5 (IR=0x99000005):
  - BranchOut=1: T6 asserts Zlowout PCin.
  - BranchOut=0: T6 all strobes 0.
  - Both cases then go to FETCH0.
- mul R3,R4 (IR=0x81A00000):
  - T4 MUL Zin; T5 Zlowout LOin; T6 Zhighout HIin.
- Halt and reset mid-instruction:
  - halt (IR=0xD8000000): Run drops at T3 and stays 0 for 10 cycles.
  - Stop=1 during FETCH0: HALT follows.
  - Clear=0 during T4 of ld: all outputs 0 on the next cycle, then a clean restart at FETCH0.
